// File: rtl/spiflash_responder.sv
// SPI flash responder: decodes 0x03 / 0xEB (continuous read) and serves bytes from a memory port.
// Pad outputs lag the host SCLK fall by SYNC_STAGES+1 clk; memory holds mem_valid until mem_ready.
module spiflash_responder #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] CONT_MASK   = 8'h30,
   parameter logic [7:0] CONT_VAL    = 8'h20
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        spi_csb,
   input  logic        spi_clk,
   input  logic [3:0]  spi_io_di,
   output logic [3:0]  spi_io_do,
   output logic [3:0]  spi_io_oe,
   input  logic [3:0]  dummy_cycles,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic [23:0] mem_addr,
   input  logic [7:0]  mem_rdata,
   output logic        busy,
   output logic        underrun
);

   typedef enum logic [2:0] {IDLE, CMD, ADDR, MODE, DUMMY, DATA, IGNORE} state_t;

   logic [5:0] sync_q [SYNC_STAGES];
   logic       csb_s, sclk_s;
   logic [3:0] io_s;
   logic       csb_prev_q, sclk_prev_q;
   logic       rise, fall, csb_fall, csb_rise;

   state_t      state_q, state_d;
   logic        cont_q, cont_d, quad_q, quad_d;
   logic [4:0]  bitcnt_q, bitcnt_d;
   logic [23:0] sr_q, sr_d, sr_nx;
   logic [23:0] addr_q, addr_d;
   logic [7:0]  dout_q, dout_d;
   logic [2:0]  dcnt_q, dcnt_d;
   logic [7:0]  buf_q, buf_d, byte_nx;
   logic        buf_vld_q, buf_vld_d;
   logic        want_q, want_d, discard_q, discard_d;
   logic        mem_valid_q, mem_valid_d;
   logic [23:0] mem_addr_q, mem_addr_d;
   logic        underrun_q, underrun_d;
   logic [3:0]  oe_q, oe_d, do_q, do_d;

   // csb synchronises to 1 so the block looks deselected out of reset
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 6'b100000;
      end else begin
         sync_q[0] <= {spi_csb, spi_clk, spi_io_di};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign csb_s    = sync_q[SYNC_STAGES-1][5];
   assign sclk_s   = sync_q[SYNC_STAGES-1][4];
   assign io_s     = sync_q[SYNC_STAGES-1][3:0];
   assign rise     = sclk_s & ~sclk_prev_q & ~csb_s;
   assign fall     = ~sclk_s & sclk_prev_q & ~csb_s;
   assign csb_fall = csb_prev_q & ~csb_s;
   assign csb_rise = ~csb_prev_q & csb_s;
   assign sr_nx    = quad_q ? {sr_q[19:0], io_s} : {sr_q[22:0], io_s[0]};
   assign byte_nx  = buf_vld_q ? buf_q : 8'hFF;

   always_comb begin
      state_d     = state_q;
      cont_d      = cont_q;
      quad_d      = quad_q;
      bitcnt_d    = bitcnt_q;
      sr_d        = sr_q;
      addr_d      = addr_q;
      dout_d      = dout_q;
      dcnt_d      = dcnt_q;
      buf_d       = buf_q;
      buf_vld_d   = buf_vld_q;
      want_d      = want_q;
      discard_d   = discard_q;
      mem_valid_d = mem_valid_q;
      mem_addr_d  = mem_addr_q;
      underrun_d  = 1'b0;
      oe_d        = oe_q;
      do_d        = do_q;

      if (mem_valid_q && mem_ready) begin
         mem_valid_d = 1'b0;
         if (discard_q) begin
            discard_d = 1'b0;
         end else begin
            buf_d     = mem_rdata;
            buf_vld_d = 1'b1;
         end
      end else if (want_q && !mem_valid_q) begin
         mem_valid_d = 1'b1;
         mem_addr_d  = addr_q;
         want_d      = 1'b0;
      end

      case (state_q)
         IDLE: if (csb_fall) begin
            bitcnt_d = '0;
            quad_d   = cont_q;
            state_d  = cont_q ? ADDR : CMD;
         end
         CMD: if (rise) begin
            sr_d     = sr_nx;
            bitcnt_d = bitcnt_q + 5'd1;
            if (bitcnt_q == 5'd7) begin
               bitcnt_d = '0;
               case (sr_nx[7:0])
                  8'h03:   state_d = ADDR;
                  8'hEB: begin
                     quad_d  = 1'b1;
                     state_d = ADDR;
                  end
                  default: state_d = IGNORE;
               endcase
            end
         end
         ADDR: if (rise) begin
            sr_d     = sr_nx;
            bitcnt_d = bitcnt_q + 5'd1;
            if (bitcnt_q == (quad_q ? 5'd5 : 5'd23)) begin
               bitcnt_d = '0;
               addr_d   = sr_nx;
               want_d   = 1'b1;
               dcnt_d   = '0;
               state_d  = quad_q ? MODE : DATA;
            end
         end
         MODE: if (rise) begin
            sr_d     = sr_nx;
            bitcnt_d = bitcnt_q + 5'd1;
            if (bitcnt_q == 5'd1) begin
               bitcnt_d = '0;
               cont_d   = (sr_nx[7:0] & CONT_MASK) == CONT_VAL;
               state_d  = (dummy_cycles == 4'd0) ? DATA : DUMMY;
            end
         end
         DUMMY: if (rise) begin
            bitcnt_d = bitcnt_q + 5'd1;
            if (bitcnt_q + 5'd1 == {1'b0, dummy_cycles}) state_d = DATA;
         end
         DATA: if (fall) begin
            oe_d = quad_q ? 4'hF : 4'b0010;
            if (dcnt_q == 3'd0) begin
               // Byte slot boundary: consume the prefetch (or 0xFF) and ask for the next address
               addr_d    = addr_q + 24'd1;
               want_d    = 1'b1;
               buf_vld_d = 1'b0;
               if (!buf_vld_q) begin
                  underrun_d = 1'b1;
                  discard_d  = mem_valid_q & ~mem_ready;
               end
               if (quad_q) begin
                  do_d   = byte_nx[7:4];
                  dout_d = {byte_nx[3:0], 4'h0};
                  dcnt_d = 3'd1;
               end else begin
                  do_d   = {2'b00, byte_nx[7], 1'b0};
                  dout_d = {byte_nx[6:0], 1'b0};
                  dcnt_d = 3'd7;
               end
            end else begin
               if (quad_q) begin
                  do_d   = dout_q[7:4];
                  dout_d = {dout_q[3:0], 4'h0};
               end else begin
                  do_d   = {2'b00, dout_q[7], 1'b0};
                  dout_d = {dout_q[6:0], 1'b0};
               end
               dcnt_d = dcnt_q - 3'd1;
            end
         end
         default: ;
      endcase

      if (csb_rise) begin
         state_d   = IDLE;
         oe_d      = 4'h0;
         do_d      = 4'h0;
         want_d    = 1'b0;
         buf_vld_d = 1'b0;
         discard_d = mem_valid_q & ~mem_ready;
         if (cont_q && (state_q == ADDR || state_q == MODE)) cont_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         csb_prev_q  <= 1'b1;
         sclk_prev_q <= 1'b0;
         state_q     <= IDLE;
         cont_q      <= 1'b0;
         quad_q      <= 1'b0;
         bitcnt_q    <= '0;
         sr_q        <= '0;
         addr_q      <= '0;
         dout_q      <= '0;
         dcnt_q      <= '0;
         buf_q       <= '0;
         buf_vld_q   <= 1'b0;
         want_q      <= 1'b0;
         discard_q   <= 1'b0;
         mem_valid_q <= 1'b0;
         mem_addr_q  <= '0;
         underrun_q  <= 1'b0;
         oe_q        <= 4'h0;
         do_q        <= 4'h0;
      end else begin
         csb_prev_q  <= csb_s;
         sclk_prev_q <= sclk_s;
         state_q     <= state_d;
         cont_q      <= cont_d;
         quad_q      <= quad_d;
         bitcnt_q    <= bitcnt_d;
         sr_q        <= sr_d;
         addr_q      <= addr_d;
         dout_q      <= dout_d;
         dcnt_q      <= dcnt_d;
         buf_q       <= buf_d;
         buf_vld_q   <= buf_vld_d;
         want_q      <= want_d;
         discard_q   <= discard_d;
         mem_valid_q <= mem_valid_d;
         mem_addr_q  <= mem_addr_d;
         underrun_q  <= underrun_d;
         oe_q        <= oe_d;
         do_q        <= do_d;
      end
   end

   assign spi_io_do = do_q;
   assign spi_io_oe = oe_q;
   assign mem_valid = mem_valid_q;
   assign mem_addr  = mem_addr_q;
   assign busy      = ~csb_s;
   assign underrun  = underrun_q;

endmodule

// File: tb/tb_spiflash_responder.sv
// Directed bench for spiflash_responder: host-side SPI driver plus a latency-programmable memory model.
module tb_spiflash_responder;
   localparam int H = 8;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        spi_csb = 1'b1;
   logic        spi_clk = 1'b0;
   logic [3:0]  spi_io_di = 4'h0;
   logic [3:0]  spi_io_do, spi_io_oe;
   logic [3:0]  dummy_cycles = 4'd8;
   logic        mem_valid;
   logic        mem_ready = 1'b0;
   logic [23:0] mem_addr;
   logic [7:0]  mem_rdata = 8'h00;
   logic        busy, underrun;

   logic [7:0]  mem [0:4095];
   int          n_chk = 0;
   int          n_fail = 0;
   int          lat = 1;
   int          slow_lat = 1;
   logic [23:0] slow_addr = 24'hABCDEF;
   int          n_underrun = 0;
   bit          saw_top = 1'b0;

   spiflash_responder #(.SYNC_STAGES(2), .CONT_MASK(8'h30), .CONT_VAL(8'h20)) dut (
      .clk(clk), .resetn(resetn), .spi_csb(spi_csb), .spi_clk(spi_clk),
      .spi_io_di(spi_io_di), .spi_io_do(spi_io_do), .spi_io_oe(spi_io_oe),
      .dummy_cycles(dummy_cycles), .mem_valid(mem_valid), .mem_ready(mem_ready),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata), .busy(busy), .underrun(underrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic sclk(input logic [3:0] io, output logic [3:0] d);
      spi_io_di = io;
      wait_clk(H);
      d = spi_io_do;
      spi_clk = 1'b1;
      wait_clk(H);
      spi_clk = 1'b0;
   endtask

   task automatic cs_lo();
      spi_csb = 1'b0;
      wait_clk(H);
   endtask

   task automatic cs_hi();
      wait_clk(H);
      spi_csb = 1'b1;
      spi_io_di = 4'h0;
      wait_clk(2*H);
   endtask

   task automatic tx_single(input logic [7:0] b);
      logic [3:0] d;
      for (int i = 7; i >= 0; i--) sclk({3'b000, b[i]}, d);
   endtask

   task automatic tx_quad(input logic [23:0] v, input int nib);
      logic [3:0] d;
      for (int i = nib - 1; i >= 0; i--) sclk(v[4*i +: 4], d);
   endtask

   task automatic idle_clocks(input int n);
      logic [3:0] d;
      repeat (n) sclk(4'h0, d);
   endtask

   task automatic rx_single(output logic [7:0] b);
      logic [3:0] d;
      for (int i = 7; i >= 0; i--) begin
         sclk(4'h0, d);
         b[i] = d[1];
      end
   endtask

   task automatic rx_quad(output logic [7:0] b);
      logic [3:0] d;
      sclk(4'h0, d);
      b[7:4] = d;
      sclk(4'h0, d);
      b[3:0] = d;
   endtask

   // Memory model: mem_ready one cycle after the programmed latency, per-address slow override
   initial begin
      int cnt;
      cnt = 0;
      forever begin
         @(negedge clk);
         if (mem_ready) begin
            mem_ready = 1'b0;
            cnt = 0;
         end else if (mem_valid) begin
            cnt++;
            if (cnt >= ((mem_addr == slow_addr) ? slow_lat : lat)) begin
               mem_ready = 1'b1;
               mem_rdata = mem[mem_addr[11:0]];
               if (mem_addr == 24'hFFFFFF) saw_top = 1'b1;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (underrun) n_underrun++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [7:0]  b;
      logic [31:0] w;
      logic [3:0]  d;
      int          t;
      for (int i = 0; i < 4096; i++) mem[i] = i[7:0] ^ 8'h5A;
      mem[12'h010] = 8'h11; mem[12'h011] = 8'h22; mem[12'h012] = 8'h33; mem[12'h013] = 8'h44;
      mem[12'h100] = 8'hDE; mem[12'h101] = 8'hAD; mem[12'h102] = 8'hBE; mem[12'h103] = 8'hEF;
      mem[12'h200] = 8'h5C; mem[12'h201] = 8'h93;
      mem[12'h300] = 8'hA1; mem[12'h301] = 8'hB2; mem[12'h302] = 8'hC3;

      wait_clk(3);
      check("rst_oe", {28'd0, spi_io_oe}, 32'h0);
      check("rst_do", {28'd0, spi_io_do}, 32'h0);
      check("rst_mem_valid", {31'd0, mem_valid}, 32'h0);
      check("rst_mem_addr", {8'd0, mem_addr}, 32'h0);
      check("rst_busy", {31'd0, busy}, 32'h0);
      check("rst_underrun", {31'd0, underrun}, 32'h0);
      resetn = 1'b1;
      wait_clk(4);

      // single-SPI read
      cs_lo();
      check("busy_low", {31'd0, busy}, 32'h1);
      tx_single(8'h03);
      tx_single(8'h00); tx_single(8'h00); tx_single(8'h10);
      rx_single(b); check("s_byte0", {24'd0, b}, 32'h11);
      check("s_oe", {28'd0, spi_io_oe}, 32'h2);
      rx_single(b); check("s_byte1", {24'd0, b}, 32'h22);
      rx_single(b); check("s_byte2", {24'd0, b}, 32'h33);
      rx_single(b); check("s_byte3", {24'd0, b}, 32'h44);
      cs_hi();
      check("s_oe_off", {28'd0, spi_io_oe}, 32'h0);
      check("busy_high", {31'd0, busy}, 32'h0);

      // quad I/O read entering continuous mode
      cs_lo();
      tx_single(8'hEB);
      tx_quad(24'h000100, 6);
      tx_quad(24'h0000A5, 2);
      idle_clocks(7);
      check("q_oe_dummy", {28'd0, spi_io_oe}, 32'h0);
      idle_clocks(1);
      for (int i = 3; i >= 0; i--) begin
         rx_quad(b);
         w[8*i +: 8] = b;
      end
      check("q_data", w, 32'hDEADBEEF);
      check("q_oe", {28'd0, spi_io_oe}, 32'hF);
      cs_hi();

      // continuous read: no command byte
      cs_lo();
      tx_quad(24'h000200, 6);
      tx_quad(24'h0000A5, 2);
      idle_clocks(8);
      rx_quad(b); w[15:8] = b;
      rx_quad(b); w[7:0] = b;
      check("cont_data", {16'd0, w[15:0]}, 32'h5C93);
      cs_hi();

      // 0xFF with io pulled high leaves continuous mode
      cs_lo();
      repeat (8) sclk(4'hF, d);
      cs_hi();
      check("ff_req_top", {31'd0, saw_top}, 32'h1);
      cs_lo();
      tx_single(8'h03);
      tx_single(8'h00); tx_single(8'h00); tx_single(8'h10);
      rx_single(b); check("after_ff", {24'd0, b}, 32'h11);
      cs_hi();
      check("no_underrun_yet", n_underrun, 32'd0);

      // slow memory on the second byte of a quad read
      slow_addr = 24'h000301;
      slow_lat = 40;
      cs_lo();
      tx_single(8'hEB);
      tx_quad(24'h000300, 6);
      tx_quad(24'h000000, 2);
      idle_clocks(8);
      rx_quad(b); check("ur_byte0", {24'd0, b}, 32'hA1);
      rx_quad(b); check("ur_byte1", {24'd0, b}, 32'hFF);
      rx_quad(b); check("ur_byte2", {24'd0, b}, 32'hC3);
      check("ur_pulses", n_underrun, 32'd1);
      cs_hi();

      // csb rise with a pending request, then reset mid-transfer
      slow_addr = 24'h000400;
      slow_lat = 100;
      cs_lo();
      tx_single(8'h03);
      tx_single(8'h00); tx_single(8'h04); tx_single(8'h00);
      idle_clocks(2);
      check("pend_oe", {28'd0, spi_io_oe}, 32'h2);
      spi_csb = 1'b1;
      wait_clk(4);
      check("csb_oe_off", {28'd0, spi_io_oe}, 32'h0);
      check("csb_do_off", {28'd0, spi_io_do}, 32'h0);
      check("pend_held", {31'd0, mem_valid}, 32'h1);
      t = 0;
      while (mem_valid && t < 300) begin
         wait_clk(1);
         t++;
      end
      check("pend_released", {31'd0, mem_valid}, 32'h0);
      wait_clk(2*H);
      slow_addr = 24'hABCDEF;
      cs_lo();
      tx_single(8'h03);
      tx_single(8'h00); tx_single(8'h00); tx_single(8'h10);
      rx_single(b); check("post_drop", {24'd0, b}, 32'h11);
      idle_clocks(2);
      check("pre_rst_oe", {28'd0, spi_io_oe}, 32'h2);
      resetn = 1'b0;
      wait_clk(1);
      check("mid_rst_oe", {28'd0, spi_io_oe}, 32'h0);
      check("mid_rst_do", {28'd0, spi_io_do}, 32'h0);
      check("mid_rst_mem_valid", {31'd0, mem_valid}, 32'h0);
      check("mid_rst_mem_addr", {8'd0, mem_addr}, 32'h0);
      check("mid_rst_busy", {31'd0, busy}, 32'h0);
      spi_csb = 1'b1;
      wait_clk(2);
      resetn = 1'b1;
      wait_clk(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
